// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame width and the baud divider
// calculation used by both the receive and transmit sides.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } rx_state_e;

  // Clocks per oversample tick, truncated; the residual rate error is absorbed by mid-bit sampling.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick generator: one-clock tick every DIV clocks.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver with 16x oversampling: synchronizes the RX pin, recovers bytes,
// and reports a ready level, a done strobe and a framing-error strobe.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 ready_flag,
  output logic                 rx_done,
  output logic                 frame_error
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic                 tick;
  rx_state_e            state_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [2:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 ready_q;
  logic                 done_q;
  logic                 ferr_q;

  baud_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Synchronizer resets to the idle line level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      // NOTE: strobes default low here and are overridden below; with non-blocking
      // assignments the last write in the block wins, which yields one-clock pulses.
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_q    <= S_START;
            tick_cnt_q <= '0;
            ready_q    <= 1'b0;
          end
        end
        S_START: begin
          if (tick) begin
            if (tick_cnt_q == HALF_LAST) begin
              if (rx_s) begin
                state_q <= S_IDLE;
              end else begin
                state_q    <= S_DATA;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (tick_cnt_q == FULL_LAST) begin
              tick_cnt_q <= '0;
              shift_q    <= {rx_s, shift_q[DATA_BITS-1:1]};
              if (bit_cnt_q == LAST_BIT) begin
                state_q <= S_STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (tick_cnt_q == FULL_LAST) begin
              tick_cnt_q <= '0;
              if (rx_s) begin
                rx_data_q <= shift_q;
                done_q    <= 1'b1;
                ready_q   <= 1'b1;
                state_q   <= S_IDLE;
              end else begin
                ferr_q  <= 1'b1;
                state_q <= S_WAIT_HIGH;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_data     = rx_data_q;
  assign ready_flag  = ready_q;
  assign rx_done     = done_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend, run with a fast baud divider (DIV=10, 160 clks/bit).
module tb_uart_rx_frontend;

  localparam int CLK_FREQ   = 1_600_000;
  localparam int BAUD       = 10_000;
  localparam int OVERSAMPLE = 16;
  localparam int BIT        = 160;
  localparam int GLITCH     = 40;
  localparam int HOLD       = 800;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       ready_flag;
  logic       rx_done;
  logic       frame_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  int         ferr_pushed = 0;
  int         ferr_seen   = 0;
  int         done_seen   = 0;
  int         rises       = 0;
  int         falls       = 0;
  logic       prev_ready  = 1'b0;
  logic       prev_done   = 1'b0;
  logic [7:0] last_good   = 8'h00;

  uart_rx_frontend #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .ready_flag (ready_flag),
    .rx_done    (rx_done),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic idle(input int clks);
    repeat (clks) @(negedge clk);
  endtask

  // Drives one 8N1 frame; a low stop bit leaves the line low on return.
  task automatic send_byte(input logic [7:0] b, input int bit_clks, input logic stop_val);
    if (stop_val) exp_q.push_back(b);
    else ferr_pushed++;
    rx = 1'b0;
    idle(bit_clks);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(bit_clks);
    end
    rx = stop_val;
    idle(bit_clks);
  endtask

  task automatic wait_drain(input int max_clks);
    int n = 0;
    while (exp_q.size() != 0 && n < max_clks) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // Output monitor: pops the scoreboard on every rx_done.
  always @(negedge clk) begin
    if (!rst) begin
      prev_ready = 1'b0;
      prev_done  = 1'b0;
      last_good  = 8'h00;
    end else begin
      if (rx_done) begin
        check("done_width", prev_done, 0);
        check("done_expected", exp_q.size() != 0, 1);
        check("ready_with_done", ready_flag, 1);
        if (exp_q.size() != 0) begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("rx_data", rx_data, e);
          last_good = e;
        end
        done_seen++;
      end
      if (frame_error) begin
        check("ferr_expected", ferr_seen < ferr_pushed, 1);
        check("ferr_data_keep", rx_data, last_good);
        ferr_seen++;
      end
      if (!prev_ready && ready_flag) rises++;
      if (prev_ready && !ready_flag) falls++;
      prev_ready = ready_flag;
      prev_done  = rx_done;
    end
  end

  initial begin
    int d0, r0, f0, e0;
    rst = 1'b0;
    rx  = 1'b1;
    idle(3);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_ready", ready_flag, 0);
    check("rst_done", rx_done, 0);
    check("rst_ferr", frame_error, 0);
    rst = 1'b1;
    idle(2 * BIT);

    // Single byte
    d0 = done_seen; r0 = rises;
    send_byte(8'h72, BIT, 1'b1);
    wait_drain(4 * BIT);
    check("t1_done_cnt", done_seen - d0, 1);
    check("t1_ready_rise", rises - r0, 1);
    check("t1_ready_level", ready_flag, 1);
    check("t1_ferr_cnt", ferr_seen, 0);
    idle(BIT);

    // Back-to-back identical bytes
    d0 = done_seen; r0 = rises; f0 = falls;
    send_byte(8'h48, BIT, 1'b1);
    send_byte(8'h48, BIT, 1'b1);
    wait_drain(4 * BIT);
    check("t2_done_cnt", done_seen - d0, 2);
    check("t2_ready_rise", rises - r0, 2);
    check("t2_ready_fall", falls - f0, 2);
    check("t2_rx_data", rx_data, 8'h48);
    idle(BIT);

    // Short glitch on the line: start rejected, ready already dropped at the start edge
    d0 = done_seen; e0 = ferr_seen;
    rx = 1'b0;
    idle(GLITCH);
    rx = 1'b1;
    idle(2 * BIT);
    check("t3_done_cnt", done_seen - d0, 0);
    check("t3_ferr_cnt", ferr_seen - e0, 0);
    check("t3_ready", ready_flag, 0);
    check("t3_rx_data", rx_data, 8'h48);

    // Low stop bit followed by a line break, then a good byte
    e0 = ferr_seen;
    send_byte(8'h55, BIT, 1'b0);
    idle(HOLD);
    rx = 1'b1;
    idle(2 * BIT);
    check("t4_ferr_cnt", ferr_seen - e0, 1);
    check("t4_rx_data_keep", rx_data, 8'h48);
    send_byte(8'h43, BIT, 1'b1);
    wait_drain(4 * BIT);
    check("t4_rx_data_next", rx_data, 8'h43);
    idle(BIT);

    // Reset in the middle of bit 4
    rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h3C >> i) & 1;
      idle(BIT);
    end
    rx = 1'b1;
    idle(BIT / 2);
    rst = 1'b0;
    #1;
    check("t5_rx_data", rx_data, 8'h00);
    check("t5_ready", ready_flag, 0);
    check("t5_done", rx_done, 0);
    check("t5_ferr", frame_error, 0);
    idle(5);
    rst = 1'b1;
    idle(2 * BIT);
    send_byte(8'h51, BIT, 1'b1);
    wait_drain(4 * BIT);
    check("t5_rx_data_after", rx_data, 8'h51);
    idle(BIT);

    // Transmitter 2% slow, then 2% fast
    e0 = ferr_seen;
    send_byte(8'hA5, 163, 1'b1);
    idle(BIT);
    send_byte(8'hA5, 157, 1'b1);
    wait_drain(4 * BIT);
    check("t6_rx_data", rx_data, 8'hA5);
    check("t6_ferr_cnt", ferr_seen - e0, 0);
    idle(BIT);

    check("total_done", done_seen, 7);
    check("total_ready_rise", rises, 7);
    check("total_ferr", ferr_seen, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
